// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet loader: word widths, the loader
// state encoding and the IEEE-754 non-finite operand test.
package maxnet_pkg;

  localparam int FP_W  = 32;
  localparam int N_ACT = 4;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    WAIT,
    RESULT
  } state_t;

  // All-ones exponent covers both infinities and every NaN payload.
  function automatic logic is_nonfinite(input logic [FP_W-1:0] word);
    return word[30:23] == 8'hFF;
  endfunction

endpackage

// File: rtl/maxnet_loader.sv
// Loader/sequencer for Maxnet_model: gathers eps and four activations from a
// word stream, fires one start pulse, waits for finish and returns the result.
module maxnet_loader
  import maxnet_pkg::*;
#(
  parameter int TIMEOUT   = 1023,
  parameter bit CHECK_NAN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [FP_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [FP_W-1:0] eps,
  output logic [FP_W-1:0] a1,
  output logic [FP_W-1:0] a2,
  output logic [FP_W-1:0] a3,
  output logic [FP_W-1:0] a4,
  output logic            start,
  input  logic            finish,
  input  logic [FP_W-1:0] mx_out,
  output logic [FP_W-1:0] res_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            err_nan,
  output logic            err_timeout,
  output logic            busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  state_t             next_state;
  logic [2:0]         word_cnt;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               in_fire;
  logic               res_fire;
  logic               tmo_hit;
  logic               word_bad;

  assign in_fire  = in_valid && in_ready;
  assign res_fire = res_valid && res_ready;
  assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign word_bad = CHECK_NAN && is_nonfinite(in_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_fire) next_state = LOAD;
      LOAD:    if (in_fire && word_cnt == 3'(N_ACT)) next_state = FIRE;
      FIRE:    next_state = WAIT;
      WAIT:    if (finish || tmo_hit) next_state = RESULT;
      RESULT:  if (res_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake/status outputs are registered from next_state so they are
  // glitch-free and all read zero while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready    <= 1'b0;
      start       <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      eps         <= '0;
      a1          <= '0;
      a2          <= '0;
      a3          <= '0;
      a4          <= '0;
      res_data    <= '0;
      word_cnt    <= '0;
      tmo_cnt     <= '0;
      err_nan     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      in_ready  <= (next_state == IDLE) || (next_state == LOAD);
      start     <= (next_state == FIRE);
      res_valid <= (next_state == RESULT);
      busy      <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (in_fire) begin
            eps         <= in_data;
            word_cnt    <= 3'd1;
            err_nan     <= word_bad;
            err_timeout <= 1'b0;
          end
        end
        LOAD: begin
          if (in_fire) begin
            case (word_cnt)
              3'd1:    a1 <= in_data;
              3'd2:    a2 <= in_data;
              3'd3:    a3 <= in_data;
              3'd4:    a4 <= in_data;
              default: ;
            endcase
            word_cnt <= (word_cnt == 3'(N_ACT)) ? 3'd0 : word_cnt + 3'd1;
            err_nan  <= err_nan | word_bad;
          end
        end
        FIRE: tmo_cnt <= '0;
        WAIT: begin
          // finish takes priority over a timeout landing on the same cycle.
          if (finish) begin
            res_data <= mx_out;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) begin
              err_timeout <= 1'b1;
              res_data    <= FP_QNAN;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_loader.sv
// Directed bench for maxnet_loader with a hand-driven Maxnet stub on
// finish/mx_out.
module tb_maxnet_loader;

  typedef logic [31:0] prob_t [5];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] eps, a1, a2, a3, a4;
  logic        start;
  logic        finish = 1'b0;
  logic [31:0] mx_out = '0;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        err_nan;
  logic        err_timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int start_pulses = 0;

  maxnet_loader #(.TIMEOUT(1023), .CHECK_NAN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .eps(eps), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .start(start), .finish(finish), .mx_out(mx_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .err_nan(err_nan), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start) start_pulses++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, output bit ok);
    in_data  = w;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    in_valid = 1'b0;
  endtask

  task automatic send_problem(input prob_t p, input bit gaps, output bit ok);
    bit w_ok;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_word(p[i], w_ok);
      ok &= w_ok;
      if (gaps && i < 4) tick();
    end
  endtask

  task automatic finish_with(input logic [31:0] v);
    finish = 1'b1;
    mx_out = v;
    tick();
    finish = 1'b0;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({eps, a1, a2, a3, a4, res_data} !== 192'h0) begin
      errors++;
      $display("FAIL reset_regs got %h want 0", {eps, a1, a2, a3, a4, res_data});
    end
    checks++;
    if ({start, res_valid, in_ready, err_nan, err_timeout, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {start, res_valid, in_ready, err_nan, err_timeout, busy});
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL idle_ready got %b want 10", {in_ready, busy});
    end
  endtask

  task automatic test_back_to_back();
    prob_t p = '{32'hBE4CCCCD, 32'h461C3FA7, 32'hC61C3FA7, 32'h0, 32'h3FA66666};
    bit ok;
    int sp = start_pulses;
    send_problem(p, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_accept got 0 want 1"); end
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL b2b_start_timing got %b want 1", start); end
    checks++;
    if ({eps, a1, a2, a3, a4} !== {p[0], p[1], p[2], p[3], p[4]}) begin
      errors++;
      $display("FAIL b2b_operands got %h want %h", {eps, a1, a2, a3, a4}, {p[0], p[1], p[2], p[3], p[4]});
    end
    tick();
    checks++;
    if ({start, busy, in_ready} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_wait_flags got %b want 010", {start, busy, in_ready});
    end
    repeat (39) tick();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_result got %b want 0", res_valid); end
    finish_with(32'h461C3FA7);
    checks++;
    if ({res_valid, res_data} !== {1'b1, 32'h461C3FA7}) begin
      errors++;
      $display("FAIL b2b_result got %b/%h want 1/461c3fa7", res_valid, res_data);
    end
    checks++;
    if (start_pulses - sp !== 1) begin
      errors++;
      $display("FAIL b2b_start_count got %0d want 1", start_pulses - sp);
    end
    release_result();
    checks++;
    if ({res_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_back_idle got %b want 010", {res_valid, in_ready, busy});
    end
  endtask

  task automatic test_gaps();
    prob_t p = '{32'hBE4CCCCD, 32'h461C3FA7, 32'hC61C3FA7, 32'h0, 32'h3FA66666};
    bit ok;
    int sp = start_pulses;
    send_problem(p, 1'b1, ok);
    checks++;
    if ({ok, start} !== 2'b11) begin errors++; $display("FAIL gap_start got %b want 11", {ok, start}); end
    checks++;
    if ({eps, a1, a2, a3, a4} !== {p[0], p[1], p[2], p[3], p[4]}) begin
      errors++;
      $display("FAIL gap_operands got %h want %h", {eps, a1, a2, a3, a4}, {p[0], p[1], p[2], p[3], p[4]});
    end
    finish = 1'b1;
    mx_out = 32'hDEADBEEF;
    tick();
    finish = 1'b0;
    repeat (3) tick();
    checks++;
    if ({res_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL gap_fire_finish_ignored got %b want 01", {res_valid, busy});
    end
    finish_with(32'h12345678);
    checks++;
    if ({res_valid, res_data} !== {1'b1, 32'h12345678}) begin
      errors++;
      $display("FAIL gap_result got %b/%h want 1/12345678", res_valid, res_data);
    end
    checks++;
    if (start_pulses - sp !== 1) begin
      errors++;
      $display("FAIL gap_start_count got %0d want 1", start_pulses - sp);
    end
    release_result();
  endtask

  task automatic test_nan();
    bit ok, all_ok;
    all_ok = 1'b1;
    send_word(32'h3F800000, ok); all_ok &= ok;
    send_word(32'h40000000, ok); all_ok &= ok;
    checks++;
    if (err_nan !== 1'b0) begin errors++; $display("FAIL nan_before got %b want 0", err_nan); end
    send_word(32'h7F800000, ok); all_ok &= ok;
    checks++;
    if ({err_nan, a2} !== {1'b1, 32'h7F800000}) begin
      errors++;
      $display("FAIL nan_set got %b/%h want 1/7f800000", err_nan, a2);
    end
    send_word(32'h40400000, ok); all_ok &= ok;
    send_word(32'h40800000, ok); all_ok &= ok;
    checks++;
    if ({all_ok, start} !== 2'b11) begin errors++; $display("FAIL nan_runs got %b want 11", {all_ok, start}); end
    tick();
    finish_with(32'hC0000000);
    checks++;
    if ({res_valid, res_data, err_nan} !== {1'b1, 32'hC0000000, 1'b1}) begin
      errors++;
      $display("FAIL nan_result got %b/%h/%b want 1/c0000000/1", res_valid, res_data, err_nan);
    end
    release_result();
    send_word(32'h3F000000, ok);
    checks++;
    if ({ok, err_nan} !== 2'b10) begin errors++; $display("FAIL nan_clear got %b want 10", {ok, err_nan}); end
    for (int i = 0; i < 4; i++) send_word(32'h3F000000, ok);
    tick();
    finish_with(32'h0);
    release_result();
  endtask

  task automatic test_hold_result();
    prob_t p = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    bit ok;
    send_problem(p, 1'b0, ok);
    tick();
    finish_with(32'hABCD0123);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({res_valid, in_ready, res_data} !== {1'b1, 1'b0, 32'hABCD0123}) begin
        errors++;
        $display("FAIL hold_stable cycle %0d got %b/%b/%h want 1/0/abcd0123", i, res_valid, in_ready, res_data);
      end
      tick();
    end
    release_result();
    checks++;
    if ({res_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release got %b want 01", {res_valid, in_ready});
    end
  endtask

  task automatic test_timeout();
    prob_t p = '{32'h3DCCCCCD, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    bit ok;
    int n = 0;
    send_problem(p, 1'b0, ok);
    while (!res_valid && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 1024) begin errors++; $display("FAIL tmo_latency got %0d want 1024", n); end
    checks++;
    if ({err_timeout, res_data} !== {1'b1, 32'h7FC00000}) begin
      errors++;
      $display("FAIL tmo_result got %b/%h want 1/7fc00000", err_timeout, res_data);
    end
    release_result();
    checks++;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b want 1", err_timeout); end
    send_word(32'h3DCCCCCD, ok);
    checks++;
    if ({ok, err_timeout} !== 2'b10) begin
      errors++;
      $display("FAIL tmo_clear got %b want 10", {ok, err_timeout});
    end
    for (int i = 1; i < 5; i++) send_word(p[i], ok);
    tick();
    finish_with(32'h1);
    release_result();
  endtask

  task automatic test_reset_mid();
    prob_t p  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    prob_t p2 = '{32'h3E800000, 32'hBF800000, 32'h7F7FFFFF, 32'h00800000, 32'h80000000};
    bit ok;
    int sp;
    send_problem(p, 1'b0, ok);
    repeat (5) tick();
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({eps, a1, a2, a3, a4, res_data} !== 192'h0) begin
      errors++;
      $display("FAIL midrst_regs got %h want 0", {eps, a1, a2, a3, a4, res_data});
    end
    checks++;
    if ({start, res_valid, in_ready, err_nan, err_timeout, busy} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_flags got %b want 000000",
               {start, res_valid, in_ready, err_nan, err_timeout, busy});
    end
    sp = start_pulses;
    tick();
    rst = 1'b1;
    tick();
    finish = 1'b1;
    mx_out = 32'hDEADBEEF;
    repeat (2) tick();
    finish = 1'b0;
    checks++;
    if ({res_valid, busy, in_ready} !== 3'b001 || start_pulses != sp) begin
      errors++;
      $display("FAIL midrst_late_finish got %b pulses %0d want 001 pulses %0d",
               {res_valid, busy, in_ready}, start_pulses, sp);
    end
    send_problem(p2, 1'b0, ok);
    checks++;
    if ({ok, start, eps, a1, a2, a3, a4} !== {1'b1, 1'b1, p2[0], p2[1], p2[2], p2[3], p2[4]}) begin
      errors++;
      $display("FAIL midrst_fresh got %b%b %h", ok, start, {eps, a1, a2, a3, a4});
    end
    tick();
    finish_with(32'h3E800000);
    checks++;
    if ({res_valid, res_data} !== {1'b1, 32'h3E800000}) begin
      errors++;
      $display("FAIL midrst_result got %b/%h want 1/3e800000", res_valid, res_data);
    end
    release_result();
  endtask

  initial begin
    $display("[TB] maxnet_loader bench start");
    test_reset();
    test_back_to_back();
    test_gaps();
    test_nan();
    test_hold_result();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxnet_loader.md
Name: maxnet_loader

Overview:
- Upstream sequencer for Maxnet_model.
- Collects one problem from a 32-bit valid/ready word stream: eps, then four IEEE-754 single-precision activations.
- Drives Maxnet_model's eps/a1..a4 and a one-cycle start pulse, waits for finish, captures out and returns it on a valid/ready result port.
- Flags NaN/Inf operands and a stalled Maxnet (timeout).

Parameters:
- TIMEOUT, 1023, max cycles in WAIT before abort; counter width = clog2(TIMEOUT+1).
- CHECK_NAN, 1, when 1 reject operands whose exponent field is 8'hFF.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_data  input  32  stream word (eps first, then a1, a2, a3, a4)
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts word this cycle
- eps  output  32  registered eps to Maxnet_model
- a1, a2, a3, a4  output  32 each  registered activations to Maxnet_model
- start  output  1  one-cycle start pulse to Maxnet_model
- finish  input  1  Maxnet_model done (level or pulse; first high cycle counts)
- mx_out  input  32  Maxnet_model out, sampled in the finish cycle
- res_data  output  32  captured result
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- err_nan  output  1  sticky: a non-finite operand was received
- err_timeout  output  1  sticky: finish not seen within TIMEOUT cycles
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE, word count=0, timeout counter=0.
  - eps, a1..a4 and res_data = 0.
  - start, res_valid, in_ready, err_nan, err_timeout and busy = 0.
- Handshakes:
  - A word transfers when in_valid && in_ready at the clock edge.
  - A result transfers when res_valid && res_ready.
  - res_data is stable while res_valid=1.
- States:
  - IDLE: in_ready=1. A transfer writes eps and sets count=1, then moves to LOAD.
  - LOAD: in_ready=1. Transfer k (k=1..4) writes a_k. After a4 moves to FIRE. in_valid gaps hold state.
  - FIRE: in_ready=0 and start=1 for exactly one cycle. Clears the timeout counter, then moves to WAIT.
  - WAIT: in_ready=0. While finish=0 the counter increments each cycle.
    - finish=1: res_data<=mx_out and go to RESULT. finish beats timeout if both occur in the same cycle.
    - Counter reaches TIMEOUT with finish=0: set err_timeout, res_data<=32'h7FC00000 (quiet NaN), go to RESULT.
  - RESULT: res_valid=1 and in_ready=0. On res_ready, drop res_valid next cycle and go to IDLE.
- Operand check (CHECK_NAN=1):
  - Any accepted word with bits[30:23]==8'hFF sets err_nan.
  - The word is still stored; the problem still runs.
  - err_nan is informational only.
- Sticky errors: err_nan and err_timeout clear only on reset, or on the eps transfer in IDLE that begins a new problem.
- Latency: word 5 accepted at edge N gives start high during cycle N+1. res_valid rises the cycle after the finish edge.
- Operand outputs hold their values from FIRE through RESULT and are never modified while Maxnet runs.
- finish outside WAIT is ignored.
- Reset mid-operation: immediate return to IDLE with all reset values; start never glitches high.
- No arithmetic on operands; raw bit patterns pass through unchanged.

Decomposition:
- Shared package maxnet_pkg:
  - FP_W=32, N_ACT=4.
  - Constant FP_QNAN=32'h7FC00000.
  - State enum {IDLE, LOAD, FIRE, WAIT, RESULT}.
  - Function is_nonfinite(word).
- No sub-module needed; a single FSM plus an operand register file.
- Optional sub-module: maxnet_timeout_cnt (clear/enable/expired).

Test Plan:
- Stream eps=32'hBE4CCCCD, a1=32'h461C3FA7, a2=32'hC61C3FA7, a3=0, a4=32'h3FA66666 back-to-back → start high exactly 1 cycle, one cycle after the a4 transfer. Stub finish after 40 cycles with mx_out=32'h461C3FA7 → res_valid=1 and res_data=32'h461C3FA7 held until res_ready.
- Same stream with in_valid toggling every other cycle → identical operand registers; start still a single pulse.
- Stub never asserts finish, TIMEOUT=1023 → after 1023 WAIT cycles err_timeout=1 and res_data=32'h7FC00000; the next problem's eps transfer clears err_timeout.
- a2=32'h7F800000 (+Inf) → err_nan=1 after that transfer; problem completes normally.
- Hold res_ready=0 for 20 cycles → res_valid/res_data stable and in_ready=0 throughout; a res_ready pulse returns to IDLE with in_ready=1 next cycle.
- Assert rst=0 during WAIT, asynchronously mid-cycle → all outputs go to 0 immediately. After release a fresh 5-word problem runs correctly, and a late finish from the stub is ignored.
